keypad_code_entry: RTL



---
 rtl/keypad_code_entry.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_code_entry.sv
// keypad_code_entry
//   Turns debounced keypad presses into key events, collects digits into a
//   code buffer and checks it against a stored access code. A long press of
//   C with the correct code in the buffer enters programming mode, where a
//   new code can be stored. Repeated failures lock the keypad for a fixed
//   number of cycles.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   key_code[3:0]   decoded key: 0-9 digit, C program, E clear, F enter
//   key_valid       high while a stable key is held
//   key_duration    cycles the current key has been stable
//   access_granted  1-cycle pulse, correct code entered
//   access_denied   1-cycle pulse, wrong/incomplete code or failed program
//   prog_done       1-cycle pulse, new code stored
//   locked          high during lockout
//   prog_mode       high while programming
//   digit_count     digits in the buffer
//   entry_buf       buffer contents, newest digit in the low nibble
module keypad_code_entry #(
  parameter int          CODE_DIGITS    = 4,
  parameter logic [15:0] LONG_PRESS     = 16'd50,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 200,
  parameter logic [31:0] DEFAULT_CODE   = 32'h1234
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               key_code,
  input  logic                     key_valid,
  input  logic [15:0]              key_duration,
  output logic                     access_granted,
  output logic                     access_denied,
  output logic                     prog_done,
  output logic                     locked,
  output logic                     prog_mode,
  output logic [2:0]               digit_count,
  output logic [4*CODE_DIGITS-1:0] entry_buf
);
  localparam int BW = 4*CODE_DIGITS;
  localparam int FW = $clog2(MAX_FAILS+1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_ENTRY, S_PROG, S_LOCK} state_t;

  state_t          r_state, w_state_nx;
  logic [BW-1:0]   r_buf, w_buf_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic [FW-1:0]   r_fail, w_fail_nx;
  logic [BW-1:0]   r_code, w_code_nx;
  logic [LW-1:0]   r_lock_cnt, w_lock_nx;
  logic            r_granted, r_denied, r_done;
  logic            w_granted_nx, w_denied_nx, w_done_nx;
  logic            r_valid_d;
  logic            r_lp_done;

  logic            w_key_evt, w_lp_evt, w_is_digit, w_full, w_match;
  logic [BW-1:0]   w_shift;
  logic [FW-1:0]   w_fail_inc;

  assign w_key_evt  = key_valid && !r_valid_d;
  // One long-press event per press: the flag blocks re-triggering until release.
  assign w_lp_evt   = key_valid && (key_code == 4'hC) &&
                      (key_duration >= LONG_PRESS) && !r_lp_done;
  assign w_is_digit = (key_code <= 4'd9);
  assign w_full     = (r_cnt == 3'(CODE_DIGITS));
  assign w_match    = w_full && (r_buf == r_code);
  // Keep the low BW bits of {buf, digit}: shift left one nibble, insert digit.
  assign w_shift    = BW'({r_buf, key_code});
  assign w_fail_inc = (r_fail == {FW{1'b1}}) ? r_fail : r_fail + 1'b1;

  always_comb begin
    w_state_nx   = r_state;
    w_buf_nx     = r_buf;
    w_cnt_nx     = r_cnt;
    w_fail_nx    = r_fail;
    w_code_nx    = r_code;
    w_lock_nx    = r_lock_cnt;
    w_granted_nx = 1'b0;
    w_denied_nx  = 1'b0;
    w_done_nx    = 1'b0;
    case (r_state)
      S_ENTRY: begin
        if (w_lp_evt) begin
          if (w_match) w_state_nx = S_PROG;
          else         w_denied_nx = 1'b1;
          w_buf_nx = '0;
          w_cnt_nx = '0;
        end else if (w_key_evt) begin
          if (w_is_digit) begin
            if (!w_full) begin
              w_buf_nx = w_shift;
              w_cnt_nx = r_cnt + 3'd1;
            end
          end else if (key_code == 4'hE) begin
            w_buf_nx = '0;
            w_cnt_nx = '0;
          end else if (key_code == 4'hF) begin
            if (w_match) begin
              w_granted_nx = 1'b1;
              w_fail_nx    = '0;
            end else begin
              w_denied_nx = 1'b1;
              w_fail_nx   = w_fail_inc;
              if (w_fail_inc == FW'(MAX_FAILS)) begin
                w_state_nx = S_LOCK;
                w_fail_nx  = '0;
                w_lock_nx  = '0;
              end
            end
            w_buf_nx = '0;
            w_cnt_nx = '0;
          end
        end
      end
      S_PROG: begin
        // Long press is meaningless here; only key events act.
        if (w_key_evt) begin
          if (w_is_digit) begin
            if (!w_full) begin
              w_buf_nx = w_shift;
              w_cnt_nx = r_cnt + 3'd1;
            end
          end else if (key_code == 4'hE) begin
            w_buf_nx   = '0;
            w_cnt_nx   = '0;
            w_state_nx = S_ENTRY;
          end else if (key_code == 4'hF) begin
            if (w_full) begin
              w_code_nx  = r_buf;
              w_done_nx  = 1'b1;
              w_state_nx = S_ENTRY;
            end else begin
              w_denied_nx = 1'b1;
            end
            w_buf_nx = '0;
            w_cnt_nx = '0;
          end
        end
      end
      S_LOCK: begin
        // All keys ignored, including one landing on the terminal cycle.
        if (r_lock_cnt == LW'(LOCKOUT_CYCLES-1)) begin
          w_lock_nx  = '0;
          w_state_nx = S_ENTRY;
        end else begin
          w_lock_nx = r_lock_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ENTRY;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_fail     <= '0;
      r_code     <= DEFAULT_CODE[BW-1:0];
      r_lock_cnt <= '0;
      r_granted  <= 1'b0;
      r_denied   <= 1'b0;
      r_done     <= 1'b0;
      r_valid_d  <= 1'b0;
      r_lp_done  <= 1'b0;
    end else begin
      r_buf      <= w_buf_nx;
      r_cnt      <= w_cnt_nx;
      r_fail     <= w_fail_nx;
      r_code     <= w_code_nx;
      r_lock_cnt <= w_lock_nx;
      r_granted  <= w_granted_nx;
      r_denied   <= w_denied_nx;
      r_done     <= w_done_nx;
      r_valid_d  <= key_valid;
      if (!key_valid)    r_lp_done <= 1'b0;
      else if (w_lp_evt) r_lp_done <= 1'b1;
    end
  end

  assign access_granted = r_granted;
  assign access_denied  = r_denied;
  assign prog_done      = r_done;
  assign locked         = (r_state == S_LOCK);
  assign prog_mode      = (r_state == S_PROG);
  assign digit_count    = r_cnt;
  assign entry_buf      = r_buf;
endmodule
